// File: rtl/prng_lfsr_stream.sv
// Galois-LFSR pseudo-random word stream. Supports run-time seeding with zero-seed
// substitution, leapfrog stepping (STEPS shifts per word) and period-wrap detection.
//
//   state | meaning
//   ------+------------------------------------------------------
//   EMPTY | no unconsumed word; out_valid=0
//   FULL  | prng_out holds a word waiting for out_ready; out_valid=1
module prng_lfsr_stream #(
    parameter int             N     = 8,
    parameter logic [N-1:0]   TAPS  = 8'hB8,
    parameter logic [N-1:0]   SEED  = {{(N-1){1'b0}}, 1'b1},
    parameter int             STEPS = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         seed_load,
    input  logic [N-1:0] seed_in,
    input  logic         out_ready,
    output logic [N-1:0] prng_out,
    output logic         out_valid,
    output logic         zero_seed,
    output logic         wrap,
    output logic [N-1:0] period_cnt
);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t       state;
    state_t       next_state;
    logic         advance;
    logic [N-1:0] lfsr;
    logic [N-1:0] seed_reg;
    logic [N-1:0] adv_val;
    logic [N-1:0] load_val;

    function automatic logic [N-1:0] lfsr_shift(input logic [N-1:0] s);
        return {1'b0, s[N-1:1]} ^ (s[0] ? TAPS : '0);
    endfunction

    // STEPS shifts unrolled so one word is still produced per clock
    always_comb begin
        adv_val = lfsr;
        for (int i = 0; i < STEPS; i++) begin
            adv_val = lfsr_shift(adv_val);
        end
    end

    assign load_val  = (seed_in == '0) ? SEED : seed_in;
    assign out_valid = (state == FULL);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= EMPTY;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        advance    = 1'b0;
        if (seed_load) begin
            next_state = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (en) begin
                        advance    = 1'b1;
                        next_state = FULL;
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        if (en) begin
                            advance = 1'b1;
                        end else begin
                            next_state = EMPTY;
                        end
                    end
                end
                default: next_state = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr       <= SEED;
            seed_reg   <= SEED;
            prng_out   <= '0;
            period_cnt <= '0;
            wrap       <= 1'b0;
            zero_seed  <= 1'b0;
        end else begin
            zero_seed <= seed_load && (seed_in == '0);
            wrap      <= advance && (adv_val == seed_reg);
            if (seed_load) begin
                lfsr       <= load_val;
                seed_reg   <= load_val;
                period_cnt <= '0;
            end else if (advance) begin
                lfsr     <= adv_val;
                prng_out <= adv_val;
                // saturate rather than roll over so long runs stay readable
                if (period_cnt != '1) begin
                    period_cnt <= period_cnt + 1'b1;
                end
            end
        end
    end

endmodule
